// File: rtl/wb4_fifo_drain_master.sv
// Wishbone B4 pipelined read master that drains a FIFO slave port into a
// first-word-fall-through skid buffer presented as a valid/ready stream.
module wb4_fifo_drain_master #(
  parameter int unsigned P_DATA_MSB    = 7,
  parameter int unsigned P_BUF_DEPTH   = 4,
  parameter int unsigned P_STALL_LIMIT = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_enable,
  output logic                o_wb4_out_mcyc,
  output logic                o_wb4_out_mstb,
  input  logic                i_wb4_out_mack,
  input  logic [P_DATA_MSB:0] i_wb4_out_mdata,
  input  logic                i_wb4_out_mstall,
  output logic                o_stream_valid,
  input  logic                i_stream_ready,
  output logic [P_DATA_MSB:0] o_stream_data,
  output logic                o_err_spurious
);

  localparam int unsigned DW   = P_DATA_MSB + 1;
  localparam int unsigned CW   = $clog2(P_BUF_DEPTH) + 1;
  localparam int unsigned PW   = $clog2(P_BUF_DEPTH);
  localparam int unsigned SUMW = CW + 1;
  localparam int unsigned SW   = $clog2(P_STALL_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_WAIT   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [DW-1:0] mem_q [P_BUF_DEPTH];

  logic          accept;
  logic          ack_any;
  logic          ack_ok;
  logic          spur;
  logic          pop;
  logic          credit_ok;
  logic [SW-1:0] stall_cnt;

  // Bus/stream events and netted counter updates for this cycle.
  always_comb begin
    accept    = stb_q & ~i_wb4_out_mstall;
    ack_any   = cyc_q & i_wb4_out_mack;
    ack_ok    = ack_any & (outst_q != '0);
    spur      = ack_any & (outst_q == '0);
    pop       = valid_q & i_stream_ready;
    outst_d   = outst_q + CW'(accept) - CW'(ack_ok);
    occ_d     = occ_q + CW'(ack_ok) - CW'(pop);
    wr_ptr_d  = ack_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    credit_ok = (SUMW'(occ_d) + SUMW'(outst_d)) < SUMW'(P_BUF_DEPTH);
    err_d     = err_q | spur;
    valid_d   = (occ_d != '0);
  end

  // Consecutive stalled-strobe count; an accepted strobe restarts it.
  always_comb begin
    stall_cnt = stall_q;
    if (accept) begin
      stall_cnt = '0;
    end else if (stb_q && i_wb4_out_mstall) begin
      stall_cnt = stall_q + SW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_enable && credit_ok) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (!i_enable || (stall_cnt >= SW'(P_STALL_LIMIT))) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (outst_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    stall_d = (state_d == S_ACTIVE) ? stall_cnt : '0;
    cyc_d   = (state_d != S_IDLE);
    stb_d   = (state_d == S_ACTIVE) && credit_ok;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      outst_q  <= '0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      outst_q  <= outst_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      stall_q  <= stall_d;
    end
  end

  // Buffer storage is cleared so the head word reads zero out of reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < P_BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (ack_ok) begin
      mem_q[wr_ptr_q] <= i_wb4_out_mdata;
    end
  end

  assign o_wb4_out_mcyc = cyc_q;
  assign o_wb4_out_mstb = stb_q;
  assign o_stream_valid = valid_q;
  assign o_stream_data  = mem_q[rd_ptr_q];
  assign o_err_spurious = err_q;

endmodule

// File: tb/tb_wb4_fifo_drain_master.sv
// Bench for wb4_fifo_drain_master: behavioural WB4 FIFO slave plus a
// scoreboard of loaded words checked against stream pops.
module tb_wb4_fifo_drain_master;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mcyc;
  logic       mstb;
  logic       mack;
  logic [7:0] mdata;
  logic       mstall;
  logic       valid;
  logic       ready;
  logic [7:0] sdata;
  logic       err;

  wb4_fifo_drain_master #(
    .P_DATA_MSB   (7),
    .P_BUF_DEPTH  (4),
    .P_STALL_LIMIT(8)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_enable        (en),
    .o_wb4_out_mcyc  (mcyc),
    .o_wb4_out_mstb  (mstb),
    .i_wb4_out_mack  (mack),
    .i_wb4_out_mdata (mdata),
    .i_wb4_out_mstall(mstall),
    .o_stream_valid  (valid),
    .i_stream_ready  (ready),
    .o_stream_data   (sdata),
    .o_err_spurious  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       rdy;
    logic       cyc;
    logic       stb;
    logic       vld;
    logic       chk_d;
    logic [7:0] d;
  } vec_t;

  int         errors;
  int         checks;
  int         cyc_n;
  int         acc_cnt;
  int         pop_cnt;
  int         ack_drv;
  int         first_pop;
  int         last_pop;
  logic       force_stall;
  logic       ack_hold;
  logic [7:0] fifo_m [$];
  logic [7:0] pend_q [$];
  logic [7:0] exp_q  [$];
  vec_t       tbl [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc_n);
    end
  endtask

  task automatic upd_stall();
    mstall = force_stall || (fifo_m.size() == 0);
  endtask

  task automatic load(input logic [7:0] w);
    fifo_m.push_back(w);
    exp_q.push_back(w);
    upd_stall();
  endtask

  // One clock: sample bus/stream handshakes, then model the FIFO slave reply.
  task automatic tick();
    logic       acc;
    logic       pp;
    logic [7:0] d;
    logic [7:0] e;
    acc = mcyc && mstb && !mstall && !rst;
    pp  = valid && ready && !rst;
    d   = sdata;
    @(posedge clk);
    #1;
    cyc_n++;
    if (acc) begin
      acc_cnt++;
      if (fifo_m.size() > 0) pend_q.push_back(fifo_m.pop_front());
    end
    if (pp) begin
      pop_cnt++;
      if (first_pop < 0) first_pop = cyc_n;
      last_pop = cyc_n;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got word 0x%0h with nothing expected (cycle %0d)", d, cyc_n);
      end else begin
        e = exp_q.pop_front();
        chk("pop_data", 32'(d), 32'(e));
      end
    end
    if (!ack_hold && pend_q.size() > 0) begin
      mack  = 1'b1;
      mdata = pend_q.pop_front();
      ack_drv++;
    end else begin
      mack  = 1'b0;
      mdata = 8'h00;
    end
    upd_stall();
  endtask

  task automatic apply_reset();
    rst         = 1'b1;
    en          = 1'b0;
    ready       = 1'b0;
    mack        = 1'b0;
    mdata       = 8'h00;
    force_stall = 1'b0;
    ack_hold    = 1'b0;
    fifo_m.delete();
    pend_q.delete();
    exp_q.delete();
    upd_stall();
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    acc_cnt   = 0;
    pop_cnt   = 0;
    ack_drv   = 0;
    first_pop = -1;
    last_pop  = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    errors = 0;
    checks = 0;
    cyc_n  = 0;

    //            en rdy cyc stb vld chk_d data
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33};
    for (int i = 6; i <= 11; i++) tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

    // Three-word stream, empty-FIFO stall release and re-entry, then disable.
    apply_reset();
    load(8'h11);
    load(8'h22);
    load(8'h33);
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("t%0d_cyc", i), 32'(mcyc), 32'(tbl[i].cyc));
      chk($sformatf("t%0d_stb", i), 32'(mstb), 32'(tbl[i].stb));
      chk($sformatf("t%0d_vld", i), 32'(valid), 32'(tbl[i].vld));
      chk($sformatf("t%0d_err", i), 32'(err), 32'(0));
      if (tbl[i].chk_d) chk($sformatf("t%0d_data", i), 32'(sdata), 32'(tbl[i].d));
      en    = tbl[i].en;
      ready = tbl[i].rdy;
      tick();
    end
    chk("t_left", 32'(exp_q.size()), 32'(0));

    // Backpressure: buffer fills to depth, strobe drops, pop re-enables it.
    apply_reset();
    for (int i = 0; i < 10; i++) load(8'(8'hA0 + i));
    en = 1'b1;
    repeat (8) tick();
    chk("bp_accepts", 32'(acc_cnt), 32'(4));
    chk("bp_stb_low", 32'(mstb), 32'(0));
    chk("bp_valid", 32'(valid), 32'(1));
    chk("bp_head", 32'(sdata), 32'(8'hA0));
    repeat (2) tick();
    chk("bp_head_stable", 32'(sdata), 32'(8'hA0));
    chk("bp_accepts_hold", 32'(acc_cnt), 32'(4));
    ready = 1'b1;
    tick();
    chk("bp_stb_reenable", 32'(mstb), 32'(1));
    guard = 0;
    while (exp_q.size() > 0 && guard < 60) begin
      tick();
      guard++;
    end
    chk("bp_left", 32'(exp_q.size()), 32'(0));
    chk("bp_total_accepts", 32'(acc_cnt), 32'(10));
    chk("bp_pops", 32'(pop_cnt), 32'(10));

    // Sustained 100-word stream at one word per cycle.
    apply_reset();
    for (int i = 0; i < 100; i++) load(8'((i * 7 + 3) & 8'hFF));
    ready = 1'b1;
    en    = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 300) begin
      tick();
      guard++;
    end
    chk("s100_left", 32'(exp_q.size()), 32'(0));
    chk("s100_pops", 32'(pop_cnt), 32'(100));
    chk("s100_span", 32'(last_pop - first_pop), 32'(99));

    // Spurious acks: ignored with CYC low, sticky error with CYC high.
    apply_reset();
    force_stall = 1'b1;
    upd_stall();
    mack  = 1'b1;
    mdata = 8'h5A;
    tick();
    chk("idle_ack_err", 32'(err), 32'(0));
    chk("idle_ack_vld", 32'(valid), 32'(0));
    en = 1'b1;
    tick();
    chk("sp_cyc", 32'(mcyc), 32'(1));
    mack  = 1'b1;
    mdata = 8'hAB;
    tick();
    chk("sp_err_set", 32'(err), 32'(1));
    chk("sp_no_push", 32'(valid), 32'(0));
    repeat (3) tick();
    chk("sp_err_sticky", 32'(err), 32'(1));
    chk("sp_no_push_late", 32'(valid), 32'(0));
    apply_reset();
    chk("sp_err_cleared", 32'(err), 32'(0));

    // Reset mid-transaction with two outstanding and two buffered words.
    apply_reset();
    for (int i = 0; i < 4; i++) load(8'(8'hC0 + i));
    en    = 1'b1;
    guard = 0;
    while (ack_drv < 2 && guard < 20) begin
      tick();
      guard++;
    end
    chk("mr_two_acks", 32'(ack_drv), 32'(2));
    ack_hold = 1'b1;
    repeat (4) tick();
    chk("mr_accepts", 32'(acc_cnt), 32'(4));
    chk("mr_pending", 32'(pend_q.size()), 32'(2));
    chk("mr_valid", 32'(valid), 32'(1));
    rst = 1'b1;
    tick();
    chk("mr_rst_cyc", 32'(mcyc), 32'(0));
    chk("mr_rst_stb", 32'(mstb), 32'(0));
    chk("mr_rst_vld", 32'(valid), 32'(0));
    chk("mr_rst_data", 32'(sdata), 32'(0));
    chk("mr_rst_err", 32'(err), 32'(0));
    exp_q.delete();
    rst      = 1'b0;
    en       = 1'b0;
    ready    = 1'b1;
    ack_hold = 1'b0;
    repeat (4) tick();
    chk("mr_late_err", 32'(err), 32'(0));
    chk("mr_late_vld", 32'(valid), 32'(0));
    chk("mr_late_drained", 32'(pend_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
